// File: rtl/platform_scroller.sv
// Sixteen-entry platform table: lays out an initial field on load and scrolls
// every platform down per frame, re-spawning those that fall off the bottom.
module platform_scroller #(
    parameter logic [8:0]  PLAT_SIZE_X  = 9'd20,
    parameter logic [8:0]  PLAT_SIZE_Y  = 9'd3,
    parameter logic [9:0]  SCREEN_Y_MAX = 10'd479,
    parameter logic [8:0]  LOAD_Y0      = 9'd460,
    parameter logic [8:0]  LOAD_DY      = 9'd28,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         frame_clk,
    input  logic         loadplat,
    input  logic         refresh_en,
    input  logic [7:0]   displacement,
    output logic [143:0] plat_x,
    output logic [143:0] plat_y,
    output logic [8:0]   plat_sizeX,
    output logic [8:0]   plat_sizeY,
    output logic         busy,
    output logic [15:0]  score
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOAD   = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;
    localparam logic [1:0] SCROLL = 2'd3;

    localparam logic [15:0] SEED      = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
    localparam logic [9:0]  WRAP_FULL = SCREEN_Y_MAX + 10'd1;
    localparam logic [8:0]  WRAP_SUB  = WRAP_FULL[8:0];

    logic [1:0]  state_r;
    logic [3:0]  idx_r;
    logic        f_q;
    logic [15:0] lfsr_r;
    logic [7:0]  disp_r;
    logic [8:0]  load_y_r;
    logic [15:0] score_r;
    logic        busy_r;
    logic [8:0]  x_r [16];
    logic [8:0]  y_r [16];

    logic        frame_rise_s;
    logic        fb_s;
    logic [15:0] lfsr_next_s;
    logic [8:0]  rand_x_s;
    logic [9:0]  ny_s;
    logic        wrap_s;
    logic [8:0]  wrap_y_s;

    assign frame_rise_s = frame_clk & ~f_q;
    assign fb_s         = lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10];
    assign lfsr_next_s  = {lfsr_r[14:0], fb_s};
    assign rand_x_s     = 9'd40 + {1'b0, lfsr_r[7:0]} + {2'b00, lfsr_r[14:8]};
    assign ny_s         = {1'b0, y_r[idx_r]} + {2'b00, disp_r};
    assign wrap_s       = (ny_s > SCREEN_Y_MAX);
    // Low 9 bits of (ny - (SCREEN_Y_MAX+1)) give the overshoot past the bottom.
    assign wrap_y_s     = ny_s[8:0] - WRAP_SUB;

    // Control FSM, LFSR, score and table updates.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r  <= IDLE;
            idx_r    <= 4'd0;
            f_q      <= 1'b0;
            lfsr_r   <= SEED;
            disp_r   <= 8'd0;
            load_y_r <= LOAD_Y0;
            score_r  <= 16'd0;
            busy_r   <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                x_r[i] <= 9'd0;
                y_r[i] <= 9'h1FF;
            end
        end else begin
            f_q <= frame_clk;
            case (state_r)
                IDLE: begin
                    if (loadplat) begin
                        state_r  <= LOAD;
                        idx_r    <= 4'd0;
                        load_y_r <= LOAD_Y0;
                        busy_r   <= 1'b1;
                    end
                end
                LOAD: begin
                    y_r[idx_r] <= load_y_r;
                    load_y_r   <= load_y_r - LOAD_DY;
                    if (idx_r == 4'd0) begin
                        x_r[idx_r] <= 9'd320;
                    end else begin
                        x_r[idx_r] <= rand_x_s;
                        lfsr_r     <= lfsr_next_s;
                    end
                    idx_r <= idx_r + 4'd1;
                    if (idx_r == 4'd15) begin
                        state_r <= WAIT;
                        busy_r  <= 1'b0;
                    end
                end
                WAIT: begin
                    if (loadplat) begin
                        state_r  <= LOAD;
                        idx_r    <= 4'd0;
                        load_y_r <= LOAD_Y0;
                        busy_r   <= 1'b1;
                    end else if (frame_rise_s && refresh_en && (displacement != 8'd0)) begin
                        disp_r  <= displacement;
                        state_r <= SCROLL;
                        idx_r   <= 4'd0;
                        busy_r  <= 1'b1;
                    end
                end
                SCROLL: begin
                    // A load request abandons the scroll before touching this entry.
                    if (loadplat) begin
                        state_r  <= LOAD;
                        idx_r    <= 4'd0;
                        load_y_r <= LOAD_Y0;
                    end else begin
                        if (wrap_s) begin
                            y_r[idx_r] <= wrap_y_s;
                            x_r[idx_r] <= rand_x_s;
                            lfsr_r     <= lfsr_next_s;
                            if (score_r != 16'hFFFF) begin
                                score_r <= score_r + 16'd1;
                            end
                        end else begin
                            y_r[idx_r] <= ny_s[8:0];
                        end
                        idx_r <= idx_r + 4'd1;
                        if (idx_r == 4'd15) begin
                            state_r <= WAIT;
                            busy_r  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < 16; g++) begin : g_pack
        assign plat_x[9*g +: 9] = x_r[g];
        assign plat_y[9*g +: 9] = y_r[g];
    end

    assign plat_sizeX = PLAT_SIZE_X;
    assign plat_sizeY = PLAT_SIZE_Y;
    assign busy       = busy_r;
    assign score      = score_r;

endmodule

// File: tb/tb_platform_scroller.sv
// Directed bench for platform_scroller: load, scroll, re-spawn boundary,
// gating, abort, saturation and reset-during-load scenarios.
module tb_platform_scroller;

    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    logic         frame_clk = 1'b0;
    logic         loadplat = 1'b0;
    logic         refresh_en = 1'b0;
    logic [7:0]   displacement = 8'd0;
    logic [143:0] plat_x;
    logic [143:0] plat_y;
    logic [8:0]   plat_sizeX;
    logic [8:0]   plat_sizeY;
    logic         busy;
    logic [15:0]  score;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] m_lfsr;
    logic [15:0] m_score;
    logic [8:0]  m_x [16];
    logic [8:0]  m_y [16];

    always #5 Clk = ~Clk;

    platform_scroller dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .loadplat(loadplat),
        .refresh_en(refresh_en), .displacement(displacement),
        .plat_x(plat_x), .plat_y(plat_y), .plat_sizeX(plat_sizeX),
        .plat_sizeY(plat_sizeY), .busy(busy), .score(score)
    );

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [8:0] rand_x(input logic [15:0] l);
        return 9'd40 + {1'b0, l[7:0]} + {2'b00, l[14:8]};
    endfunction

    function automatic logic [8:0] px(input int i);
        return plat_x[9*i +: 9];
    endfunction

    function automatic logic [8:0] py(input int i);
        return plat_y[9*i +: 9];
    endfunction

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic model_reset;
        m_lfsr  = 16'hACE1;
        m_score = 16'd0;
        for (int i = 0; i < 16; i++) begin
            m_x[i] = 9'd0;
            m_y[i] = 9'h1FF;
        end
    endtask

    task automatic model_load;
        m_x[0] = 9'd320;
        m_y[0] = 9'd460;
        for (int i = 1; i < 16; i++) begin
            m_x[i] = rand_x(m_lfsr);
            m_lfsr = lfsr_step(m_lfsr);
            m_y[i] = 9'(460 - 28 * i);
        end
    endtask

    task automatic model_scroll(input int d, input int n);
        int ny;
        for (int i = 0; i < n; i++) begin
            ny = int'(m_y[i]) + d;
            if (ny > 479) begin
                m_x[i] = rand_x(m_lfsr);
                m_lfsr = lfsr_step(m_lfsr);
                m_y[i] = 9'(ny - 480);
                if (m_score != 16'hFFFF) m_score = m_score + 16'd1;
            end else begin
                m_y[i] = 9'(ny);
            end
        end
    endtask

    // Raises frame_clk for one cycle and counts busy over the following cycles.
    task automatic frame_edge(input logic [7:0] d, input logic en, input int cycles, output int bc);
        bc = 0;
        displacement = d;
        refresh_en = en;
        frame_clk = 1'b1;
        for (int k = 0; k < cycles; k++) begin
            tick();
            frame_clk = 1'b0;
            bc += int'(busy);
        end
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        refresh_en = 1'b1;
        displacement = 8'd5;
        for (int k = 0; k < 8; k++) begin
            frame_clk = ~frame_clk;
            tick();
        end
        frame_clk = 1'b0;
        model_reset();
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_cmp++;
        if (score !== 16'd0) begin n_bad++; $display("FAIL reset_score: got %0d want 0", score); end
        n_cmp++;
        if (plat_sizeX !== 9'd20 || plat_sizeY !== 9'd3)
            begin n_bad++; $display("FAIL sizes: got %0d/%0d want 20/3", plat_sizeX, plat_sizeY); end
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (px(i) !== 9'd0 || py(i) !== 9'd511) begin
                n_bad++;
                $display("FAIL reset_entry[%0d]: got (%0d,%0d) want (0,511)", i, px(i), py(i));
            end
        end
    endtask

    task automatic test_load;
        int bc;
        bc = 0;
        loadplat = 1'b1;
        for (int k = 0; k < 17; k++) begin
            tick();
            loadplat = (k == 4);
            bc += int'(busy);
        end
        loadplat = 1'b0;
        model_load();
        n_cmp++;
        if (bc != 16 || busy !== 1'b0) begin n_bad++; $display("FAIL load_busy: got %0d cycles want 16", bc); end
        n_cmp++;
        if (px(0) !== 9'd320 || py(0) !== 9'd460)
            begin n_bad++; $display("FAIL load_entry0: got (%0d,%0d) want (320,460)", px(0), py(0)); end
        n_cmp++;
        if (px(1) !== 9'd309) begin n_bad++; $display("FAIL load_x1: got %0d want 309", px(1)); end
        n_cmp++;
        if (px(2) !== 9'd324) begin n_bad++; $display("FAIL load_x2: got %0d want 324", px(2)); end
        n_cmp++;
        if (py(15) !== 9'd40) begin n_bad++; $display("FAIL load_y15: got %0d want 40", py(15)); end
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (px(i) < 9'd40 || px(i) > 9'd422 || px(i) !== m_x[i] || py(i) !== m_y[i]) begin
                n_bad++;
                $display("FAIL load_entry[%0d]: got (%0d,%0d) want (%0d,%0d)", i, px(i), py(i), m_x[i], m_y[i]);
            end
        end
    endtask

    task automatic test_scroll_plain;
        int bc;
        frame_edge(8'd10, 1'b1, 17, bc);
        model_scroll(10, 16);
        n_cmp++;
        if (bc != 16 || busy !== 1'b0) begin n_bad++; $display("FAIL scroll_busy: got %0d cycles want 16", bc); end
        n_cmp++;
        if (py(0) !== 9'd470 || px(0) !== 9'd320)
            begin n_bad++; $display("FAIL scroll_entry0: got (%0d,%0d) want (320,470)", px(0), py(0)); end
        n_cmp++;
        if (score !== 16'd0) begin n_bad++; $display("FAIL scroll_score: got %0d want 0", score); end
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (px(i) !== m_x[i] || py(i) !== m_y[i]) begin
                n_bad++;
                $display("FAIL scroll_entry[%0d]: got (%0d,%0d) want (%0d,%0d)", i, px(i), py(i), m_x[i], m_y[i]);
            end
        end
    endtask

    task automatic test_respawn_boundary;
        int bc;
        frame_edge(8'd8, 1'b1, 17, bc);
        model_scroll(8, 16);
        n_cmp++;
        if (py(0) !== 9'd478 || px(0) !== 9'd320)
            begin n_bad++; $display("FAIL bound_478: got (%0d,%0d) want (320,478)", px(0), py(0)); end
        frame_edge(8'd1, 1'b1, 17, bc);
        model_scroll(1, 16);
        n_cmp++;
        if (py(0) !== 9'd479 || px(0) !== 9'd320 || score !== 16'd0)
            begin n_bad++; $display("FAIL bound_479: got (%0d,%0d) score %0d want (320,479) score 0", px(0), py(0), score); end
        frame_edge(8'd1, 1'b1, 17, bc);
        model_scroll(1, 16);
        n_cmp++;
        if (py(0) !== 9'd0 || score !== 16'd1)
            begin n_bad++; $display("FAIL bound_480: got y %0d score %0d want y 0 score 1", py(0), score); end
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (px(i) !== m_x[i] || py(i) !== m_y[i]) begin
                n_bad++;
                $display("FAIL bound_entry[%0d]: got (%0d,%0d) want (%0d,%0d)", i, px(i), py(i), m_x[i], m_y[i]);
            end
        end
    endtask

    task automatic test_gating;
        int bc;
        frame_edge(8'd50, 1'b0, 20, bc);
        n_cmp++;
        if (bc != 0) begin n_bad++; $display("FAIL gate_refresh: got %0d busy cycles want 0", bc); end
        frame_edge(8'd0, 1'b1, 20, bc);
        n_cmp++;
        if (bc != 0) begin n_bad++; $display("FAIL gate_zero: got %0d busy cycles want 0", bc); end
        bc = 0;
        displacement = 8'd5;
        refresh_en = 1'b1;
        frame_clk = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            frame_clk = (k == 3);
            if (k == 0) displacement = 8'd99;
            bc += int'(busy);
        end
        displacement = 8'd0;
        model_scroll(5, 16);
        n_cmp++;
        if (bc != 16) begin n_bad++; $display("FAIL gate_double: got %0d busy cycles want 16", bc); end
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (px(i) !== m_x[i] || py(i) !== m_y[i]) begin
                n_bad++;
                $display("FAIL gate_entry[%0d]: got (%0d,%0d) want (%0d,%0d)", i, px(i), py(i), m_x[i], m_y[i]);
            end
        end
    endtask

    task automatic test_abort;
        int bc;
        bc = 0;
        displacement = 8'd3;
        refresh_en = 1'b1;
        frame_clk = 1'b1;
        for (int k = 0; k < 25; k++) begin
            tick();
            frame_clk = 1'b0;
            loadplat = (k == 7);
            bc += int'(busy);
        end
        loadplat = 1'b0;
        model_scroll(3, 7);
        model_load();
        n_cmp++;
        if (bc != 24 || busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %0d cycles want 24", bc); end
        n_cmp++;
        if (score !== m_score) begin n_bad++; $display("FAIL abort_score: got %0d want %0d", score, m_score); end
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (px(i) !== m_x[i] || py(i) !== m_y[i]) begin
                n_bad++;
                $display("FAIL abort_entry[%0d]: got (%0d,%0d) want (%0d,%0d)", i, px(i), py(i), m_x[i], m_y[i]);
            end
        end
    endtask

    task automatic test_saturation;
        int bc;
        force dut.score_r = 16'hFFFF;
        tick();
        release dut.score_r;
        tick();
        m_score = 16'hFFFF;
        n_cmp++;
        if (score !== 16'hFFFF) begin n_bad++; $display("FAIL sat_preset: got %h want ffff", score); end
        frame_edge(8'd200, 1'b1, 17, bc);
        model_scroll(200, 16);
        n_cmp++;
        if (score !== 16'hFFFF) begin n_bad++; $display("FAIL sat_hold: got %h want ffff", score); end
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (px(i) !== m_x[i] || py(i) !== m_y[i]) begin
                n_bad++;
                $display("FAIL sat_entry[%0d]: got (%0d,%0d) want (%0d,%0d)", i, px(i), py(i), m_x[i], m_y[i]);
            end
        end
    endtask

    task automatic test_reset_mid_load;
        int bc;
        loadplat = 1'b1;
        tick();
        loadplat = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        model_reset();
        n_cmp++;
        if (busy !== 1'b0 || score !== 16'd0)
            begin n_bad++; $display("FAIL rst_load_ctrl: got busy %0b score %0d want 0/0", busy, score); end
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (px(i) !== 9'd0 || py(i) !== 9'd511) begin
                n_bad++;
                $display("FAIL rst_load_entry[%0d]: got (%0d,%0d) want (0,511)", i, px(i), py(i));
            end
        end
        tick();
        bc = 0;
        loadplat = 1'b1;
        for (int k = 0; k < 17; k++) begin
            tick();
            loadplat = 1'b0;
            bc += int'(busy);
        end
        model_load();
        n_cmp++;
        if (bc != 16 || px(1) !== 9'd309)
            begin n_bad++; $display("FAIL reload: got busy %0d x1 %0d want 16/309", bc, px(1)); end
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (px(i) !== m_x[i] || py(i) !== m_y[i]) begin
                n_bad++;
                $display("FAIL reload_entry[%0d]: got (%0d,%0d) want (%0d,%0d)", i, px(i), py(i), m_x[i], m_y[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_scroll_plain();
        test_respawn_boundary();
        test_gating();
        test_abort();
        test_saturation();
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
